// File: rtl/control_fsm.sv
// Multicycle main control unit for the single-bus RV32I-subset core.
// Sequences fetch/decode/execute/memory/writeback and counts retired instructions.
module control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             branch,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       aluOp,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
  // DECODE   | branch/jal target (oldPC+imm) into ALUOut, dispatch on opcode
  // MEMADR   | rs1+imm into ALUOut for lw/sw
  // MEMREAD  | data read at ALUOut, waits on mem_ready
  // MEMWB    | memory data to rd
  // MEMWRITE | data write at ALUOut, waits on mem_ready
  // EXECR    | rs1 op rs2
  // EXECI    | rs1 op imm
  // ALUWB    | ALUOut to rd
  // BRANCH   | compare rs1/rs2, PC <= ALUOut when taken
  // JAL      | PC <= ALUOut (target), ALUOut <= oldPC+4
  // TRAP     | unsupported opcode, parked until reset

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_ITYP = 2'b01;
  localparam logic [1:0] ALUOP_RTYP = 2'b10;

  state_t           state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  logic       mem_req_c, mem_write_c, adr_src_c;
  logic       ir_write_c, pc_write_c, reg_write_c;
  logic [1:0] alu_src_a_c, alu_src_b_c, result_src_c, aluop_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) begin
        illegal_q <= 1'b1;
      end
      if (retire) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    mem_req_c    = 1'b0;
    mem_write_c  = 1'b0;
    adr_src_c    = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = SRCA_PC;
    alu_src_b_c  = SRCB_RS2;
    result_src_c = RES_ALUOUT;
    aluop_c      = ALUOP_ADD;

    case (state_q)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_FOUR;
        result_src_c = RES_ALU;
        ir_write_c   = mem_ready;
        pc_write_c   = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_IMM;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ADDI:      state_d = S_EXECI;
          OP_BRANCH:    state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
        state_d     = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end
      end

      S_MEMWB: begin
        result_src_c = RES_MEM;
        reg_write_c  = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end

      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_EXECR: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_RS2;
        aluop_c     = ALUOP_RTYP;
        state_d     = S_ALUWB;
      end

      S_EXECI: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
        aluop_c     = ALUOP_ITYP;
        state_d     = S_ALUWB;
      end

      S_ALUWB: begin
        result_src_c = RES_ALUOUT;
        reg_write_c  = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a_c  = SRCA_RS1;
        alu_src_b_c  = SRCB_RS2;
        result_src_c = RES_ALUOUT;
        pc_write_c   = branch;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end

      // jal retires in the following ALUWB, which writes oldPC+4 to rd
      S_JAL: begin
        alu_src_a_c  = SRCA_OLDPC;
        alu_src_b_c  = SRCB_FOUR;
        result_src_c = RES_ALUOUT;
        pc_write_c   = 1'b1;
        state_d      = S_ALUWB;
      end

      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // reset masks every output so an abandoned access never raises an enable
  assign mem_req    = rst_n & mem_req_c;
  assign mem_write  = rst_n & mem_write_c;
  assign adr_src    = rst_n & adr_src_c;
  assign ir_write   = rst_n & ir_write_c;
  assign pc_write   = rst_n & pc_write_c;
  assign reg_write  = rst_n & reg_write_c;
  assign alu_src_a  = rst_n ? alu_src_a_c  : 2'b00;
  assign alu_src_b  = rst_n ? alu_src_b_c  : 2'b00;
  assign result_src = rst_n ? result_src_c : 2'b00;
  assign aluOp      = rst_n ? aluop_c      : 2'b00;
  assign illegal    = rst_n & illegal_q;
  assign instret    = rst_n ? cnt_q : '0;

endmodule
